sync_frame_tx: RTL and testbench

Serial frame transmitter that emits the 8-bit sync word `10110110` MSB-first, followed by a fixed number of payload bytes, one bit per clock. Payload bytes come in over a valid/ready byte interface. The block is the transmit end of the serial link whose receive end is the sync-word detector. `bit_out`/`bit_valid` drive the detector's `bit_in`/`valid` directly in loopback.

---
 rtl/sync_link_pkg.sv | 16 +
 rtl/sync_frame_tx.sv | 147 ++++++++++++++
 tb/tb_sync_frame_tx.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_link_pkg.sv
// Shared definitions for the serial sync link (frame transmitter and sync-word detector).
package sync_link_pkg;

    // Transmitter state encoding; encodings 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        ABORT = 3'd3,
        GAP   = 3'd4
    } link_state_e;

    // Header byte shared by transmitter and detector.
    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'b10110110;

endpackage

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word MSB-first, then PAYLOAD_BYTES payload bytes, then
// GAP_CYCLES idle bit-times. Payload arrives through a single-entry valid/ready holding register.
module sync_frame_tx
    import sync_link_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int unsigned PAYLOAD_BYTES = 2,
    parameter int unsigned GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       underrun
);

    localparam logic [3:0]  LastByte   = 4'(PAYLOAD_BYTES - 1);
    // GAP is entered with the counter preloaded so it lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0]  GapLoad    = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam link_state_e AfterFrame = (GAP_CYCLES == 0) ? IDLE : GAP;

    link_state_e state_q, state_d;
    logic [7:0]  hold_reg_q, hold_reg_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  bytecnt_q, bytecnt_d;
    logic [3:0]  gapcnt_q, gapcnt_d;
    logic        load;
    logic        accept;

    assign accept = data_valid & ~hold_full_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; also decides when the holding register is moved into the shifter.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_full_q) state_d = SYNC;
            end
            SYNC: begin
                if (bitcnt_q == 3'd0) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = DATA;
                    end else begin
                        state_d = ABORT;
                    end
                end
            end
            DATA: begin
                if (bitcnt_q == 3'd0) begin
                    // bytecnt_q still counts completed bytes before this one.
                    if (bytecnt_q == LastByte) begin
                        state_d = AfterFrame;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: state_d = AfterFrame;
            GAP: begin
                if (gapcnt_q == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: holding register, shifter and counters.
    always_comb begin
        hold_full_d = (hold_full_q & ~load) | accept;
        hold_reg_d  = accept ? data_in : hold_reg_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        bytecnt_d   = bytecnt_q;
        gapcnt_d    = gapcnt_q;

        case (state_q)
            IDLE: begin
                shreg_d   = SYNC_WORD;
                bitcnt_d  = 3'd7;
                bytecnt_d = 4'd0;
            end
            SYNC, DATA: begin
                shreg_d  = {shreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q - 3'd1;
                if (state_q == DATA && bitcnt_q == 3'd0) bytecnt_d = bytecnt_q + 4'd1;
                if (load) begin
                    shreg_d  = hold_reg_q;
                    bitcnt_d = 3'd7;
                end
            end
            default: ;
        endcase

        if (state_q != GAP && state_d == GAP) begin
            gapcnt_d = GapLoad;
        end else if (state_q == GAP) begin
            gapcnt_d = gapcnt_q - 4'd1;
        end
    end

    // Datapath registers; reset discards any held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg_q  <= 8'h00;
            hold_full_q <= 1'b0;
            shreg_q     <= 8'h00;
            bitcnt_q    <= 3'd0;
            bytecnt_q   <= 4'd0;
            gapcnt_q    <= 4'd0;
        end else begin
            hold_reg_q  <= hold_reg_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            bytecnt_q   <= bytecnt_d;
            gapcnt_q    <= gapcnt_d;
        end
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        data_ready = ~hold_full_q;
        bit_valid  = (state_q == SYNC) || (state_q == DATA);
        bit_out    = bit_valid & shreg_q[7];
        busy       = (state_q == SYNC) || (state_q == DATA) || (state_q == GAP);
        underrun   = (state_q == ABORT);
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default instance (2 payload bytes, 1 gap cycle) and a
// short-frame instance (1 payload byte, no gap).
module tb_sync_frame_tx;
    import sync_link_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, data_valid_a, data_ready_a, bit_out_a, bit_valid_a, busy_a, underrun_a;
    logic [7:0] data_in_a;
    logic       reset_b, data_valid_b, data_ready_b, bit_out_b, bit_valid_b, busy_b, underrun_b;
    logic [7:0] data_in_b;

    sync_frame_tx u_dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .data_in   (data_in_a),
        .data_valid(data_valid_a),
        .data_ready(data_ready_a),
        .bit_out   (bit_out_a),
        .bit_valid (bit_valid_a),
        .busy      (busy_a),
        .underrun  (underrun_a)
    );

    sync_frame_tx #(
        .PAYLOAD_BYTES(1),
        .GAP_CYCLES   (0)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .data_in   (data_in_b),
        .data_valid(data_valid_b),
        .data_ready(data_ready_b),
        .bit_out   (bit_out_b),
        .bit_valid (bit_valid_b),
        .busy      (busy_b),
        .underrun  (underrun_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Byte sources and their acceptance bookkeeping.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] sink;
    logic       pend_a = 1'b0;
    logic       pend_b = 1'b0;

    // Monitor state for instance A.
    int          acc_a, first_acc_a, nvalid_a, nunder_a, under_cyc_a, hits_a, hit_idx_a;
    int          stray_a, rdy_fall_a, last_v_a;
    int          starts_a[$];
    logic [63:0] bits_a;
    logic [7:0]  win_a;
    logic        pv_a, prdy_a;

    // Monitor state for instance B.
    int          acc_b, nvalid_b, nunder_b;
    int          starts_b[$];
    logic [63:0] bits_b;
    logic        pv_b;

    int d1, d2;

    task automatic clear_mon();
        acc_a = 0; first_acc_a = -1; nvalid_a = 0; nunder_a = 0; under_cyc_a = -1;
        hits_a = 0; hit_idx_a = -1; stray_a = 0; rdy_fall_a = 0; last_v_a = -1;
        starts_a.delete(); bits_a = '0; win_a = '0; pv_a = bit_valid_a; prdy_a = data_ready_a;
        acc_b = 0; nvalid_b = 0; nunder_b = 0;
        starts_b.delete(); bits_b = '0; pv_b = bit_valid_b;
    endtask

    // One clock: sample on the falling edge, update monitors, then drive the sources.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend_a) begin
            sink = q_a.pop_front();
            if (acc_a == 0) first_acc_a = cyc;
            acc_a++;
        end
        if (pend_b) begin
            sink = q_b.pop_front();
            acc_b++;
        end
        if (bit_valid_a === 1'b1) begin
            if (!pv_a) starts_a.push_back(cyc);
            bits_a = {bits_a[62:0], bit_out_a};
            nvalid_a++;
            last_v_a = cyc;
            win_a = {win_a[6:0], bit_out_a};
            if (win_a == SYNC_WORD_DEFAULT) begin
                hits_a++;
                hit_idx_a = nvalid_a;
            end
        end
        if (bit_out_a === 1'b1 && bit_valid_a !== 1'b1) stray_a++;
        if (underrun_a === 1'b1) begin
            nunder_a++;
            under_cyc_a = cyc;
        end
        if (prdy_a && data_ready_a === 1'b0) rdy_fall_a++;
        prdy_a = (data_ready_a === 1'b1);
        pv_a = (bit_valid_a === 1'b1);
        if (bit_valid_b === 1'b1) begin
            if (!pv_b) starts_b.push_back(cyc);
            bits_b = {bits_b[62:0], bit_out_b};
            nvalid_b++;
        end
        if (underrun_b === 1'b1) nunder_b++;
        pv_b = (bit_valid_b === 1'b1);

        data_valid_a = (q_a.size() != 0);
        data_in_a    = data_valid_a ? q_a[0] : 8'h00;
        pend_a       = data_valid_a && (data_ready_a === 1'b1);
        data_valid_b = (q_b.size() != 0);
        data_in_b    = data_valid_b ? q_b[0] : 8'h00;
        pend_b       = data_valid_b && (data_ready_b === 1'b1);
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) step();
        checks++; if (data_ready_a !== 1'b1) begin errors++;
            $display("FAIL reset_data_ready got %b want 1", data_ready_a); end
        checks++; if (bit_out_a !== 1'b0) begin errors++;
            $display("FAIL reset_bit_out got %b want 0", bit_out_a); end
        checks++; if (bit_valid_a !== 1'b0) begin errors++;
            $display("FAIL reset_bit_valid got %b want 0", bit_valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (underrun_a !== 1'b0) begin errors++;
            $display("FAIL reset_underrun got %b want 0", underrun_a); end
        checks++; if (data_ready_b !== 1'b1) begin errors++;
            $display("FAIL reset_b_data_ready got %b want 1", data_ready_b); end
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();
        clear_mon();
    endtask

    task automatic test_frame();
        clear_mon();
        q_a.push_back(8'h3C);
        q_a.push_back(8'hA5);
        for (int i = 0; i < 60 && nvalid_a < 24; i++) step();
        checks++; if (nvalid_a !== 24) begin errors++;
            $display("FAIL frame_nbits got %0d want 24", nvalid_a); end
        checks++; if (bits_a[23:0] !== 24'hB63CA5) begin errors++;
            $display("FAIL frame_bits got %h want b63ca5", bits_a[23:0]); end
        checks++; if (starts_a.size() !== 1) begin errors++;
            $display("FAIL frame_contiguous got %0d runs want 1", starts_a.size()); end
        d1 = (starts_a.size() > 0) ? starts_a[0] - first_acc_a : -1;
        checks++; if (d1 !== 1) begin errors++;
            $display("FAIL frame_first_latency got %0d want 1", d1); end
        step();
        checks++; if (bit_valid_a !== 1'b0 || busy_a !== 1'b1) begin errors++;
            $display("FAIL frame_gap got valid=%b busy=%b want valid=0 busy=1",
                     bit_valid_a, busy_a); end
        step();
        checks++; if (busy_a !== 1'b0 || bit_valid_a !== 1'b0) begin errors++;
            $display("FAIL frame_idle got busy=%b valid=%b want 0 0", busy_a, bit_valid_a); end
        checks++; if (nunder_a !== 0 || stray_a !== 0) begin errors++;
            $display("FAIL frame_clean got underruns=%0d stray=%0d want 0 0",
                     nunder_a, stray_a); end
    endtask

    task automatic test_loopback();
        clear_mon();
        q_a.push_back(8'h00);
        q_a.push_back(8'h00);
        for (int i = 0; i < 60 && nvalid_a < 24; i++) step();
        repeat (3) step();
        checks++; if (bits_a[23:0] !== 24'hB60000) begin errors++;
            $display("FAIL loop_bits got %h want b60000", bits_a[23:0]); end
        checks++; if (hits_a !== 1) begin errors++;
            $display("FAIL loop_hits got %0d want 1", hits_a); end
        checks++; if (hit_idx_a !== 8) begin errors++;
            $display("FAIL loop_hit_bit got %0d want 8", hit_idx_a); end
    endtask

    task automatic test_underrun();
        clear_mon();
        q_a.push_back(8'h3C);
        for (int i = 0; i < 60 && nvalid_a < 16; i++) step();
        step();
        checks++; if (underrun_a !== 1'b1 || bit_valid_a !== 1'b0) begin errors++;
            $display("FAIL under_pulse got underrun=%b valid=%b want 1 0",
                     underrun_a, bit_valid_a); end
        step();
        checks++; if (underrun_a !== 1'b0 || busy_a !== 1'b1 || bit_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL under_gap got underrun=%b busy=%b valid=%b want 0 1 0",
                     underrun_a, busy_a, bit_valid_a); end
        step();
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL under_idle got busy=%b want 0", busy_a); end
        repeat (10) step();
        checks++; if (nunder_a !== 1) begin errors++;
            $display("FAIL under_count got %0d want 1", nunder_a); end
        checks++; if (under_cyc_a !== last_v_a + 1) begin errors++;
            $display("FAIL under_timing got cycle %0d want %0d", under_cyc_a, last_v_a + 1); end
        checks++; if (nvalid_a !== 16 || bits_a[15:0] !== 16'hB63C) begin errors++;
            $display("FAIL under_bits got %0d bits %h want 16 bits b63c",
                     nvalid_a, bits_a[15:0]); end
        // A later byte starts a fresh frame.
        clear_mon();
        q_a.push_back(8'h5A);
        q_a.push_back(8'h0F);
        for (int i = 0; i < 60 && nvalid_a < 24; i++) step();
        repeat (3) step();
        checks++; if (bits_a[23:0] !== 24'hB65A0F || nvalid_a !== 24) begin errors++;
            $display("FAIL under_fresh got %0d bits %h want 24 bits b65a0f",
                     nvalid_a, bits_a[23:0]); end
        d1 = (starts_a.size() > 0) ? starts_a[0] - first_acc_a : -1;
        checks++; if (d1 !== 1) begin errors++;
            $display("FAIL under_fresh_latency got %0d want 1", d1); end
        checks++; if (nunder_a !== 0) begin errors++;
            $display("FAIL under_fresh_clean got %0d underruns want 0", nunder_a); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        q_a.push_back(8'h11); q_a.push_back(8'h22); q_a.push_back(8'h33);
        q_a.push_back(8'h44); q_a.push_back(8'h55); q_a.push_back(8'h66);
        for (int i = 0; i < 200 && nvalid_a < 72; i++) step();
        repeat (3) step();
        checks++; if (starts_a.size() !== 3) begin errors++;
            $display("FAIL b2b_frames got %0d want 3", starts_a.size()); end
        d1 = (starts_a.size() > 1) ? starts_a[1] - starts_a[0] : -1;
        d2 = (starts_a.size() > 2) ? starts_a[2] - starts_a[1] : -1;
        checks++; if (d1 !== 26) begin errors++;
            $display("FAIL b2b_spacing1 got %0d want 26", d1); end
        checks++; if (d2 !== 26) begin errors++;
            $display("FAIL b2b_spacing2 got %0d want 26", d2); end
        checks++; if (bits_a[47:0] !== 48'hB63344_B65566) begin errors++;
            $display("FAIL b2b_bits got %h want b63344b65566", bits_a[47:0]); end
        checks++; if (acc_a !== 6 || rdy_fall_a !== 6) begin errors++;
            $display("FAIL b2b_accepts got acc=%0d falls=%0d want 6 6", acc_a, rdy_fall_a); end
        checks++; if (nunder_a !== 0 || nvalid_a !== 72) begin errors++;
            $display("FAIL b2b_clean got underruns=%0d bits=%0d want 0 72", nunder_a, nvalid_a);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        q_a.push_back(8'h3C);
        q_a.push_back(8'hA5);
        for (int i = 0; i < 60 && nvalid_a < 12; i++) step();
        reset_a = 1'b1;
        step();
        checks++; if (bit_valid_a !== 1'b0 || bit_out_a !== 1'b0) begin errors++;
            $display("FAIL rmid_bits got valid=%b out=%b want 0 0", bit_valid_a, bit_out_a); end
        checks++; if (busy_a !== 1'b0 || underrun_a !== 1'b0) begin errors++;
            $display("FAIL rmid_status got busy=%b underrun=%b want 0 0", busy_a, underrun_a); end
        checks++; if (data_ready_a !== 1'b1) begin errors++;
            $display("FAIL rmid_ready got %b want 1", data_ready_a); end
        reset_a = 1'b0;
        repeat (4) step();
        checks++; if (bit_valid_a !== 1'b0 || nunder_a !== 0) begin errors++;
            $display("FAIL rmid_quiet got valid=%b underruns=%0d want 0 0",
                     bit_valid_a, nunder_a); end
        clear_mon();
        q_a.push_back(8'h81);
        q_a.push_back(8'h7E);
        for (int i = 0; i < 60 && nvalid_a < 24; i++) step();
        repeat (3) step();
        d1 = (starts_a.size() > 0) ? starts_a[0] - first_acc_a : -1;
        checks++; if (d1 !== 1) begin errors++;
            $display("FAIL rmid_latency got %0d want 1", d1); end
        checks++; if (bits_a[23:0] !== 24'hB6817E || nvalid_a !== 24) begin errors++;
            $display("FAIL rmid_frame got %0d bits %h want 24 bits b6817e",
                     nvalid_a, bits_a[23:0]); end
    endtask

    task automatic test_short_frame();
        clear_mon();
        q_b.push_back(8'hC3);
        q_b.push_back(8'h18);
        q_b.push_back(8'h7E);
        for (int i = 0; i < 150 && nvalid_b < 48; i++) step();
        repeat (3) step();
        checks++; if (starts_b.size() !== 3) begin errors++;
            $display("FAIL short_frames got %0d want 3", starts_b.size()); end
        d1 = (starts_b.size() > 1) ? starts_b[1] - starts_b[0] : -1;
        d2 = (starts_b.size() > 2) ? starts_b[2] - starts_b[1] : -1;
        checks++; if (d1 !== 17 || d2 !== 17) begin errors++;
            $display("FAIL short_spacing got %0d,%0d want 17,17", d1, d2); end
        checks++; if (bits_b[47:0] !== 48'hB6C3_B618_B67E) begin errors++;
            $display("FAIL short_bits got %h want b6c3b618b67e", bits_b[47:0]); end
        checks++; if (nunder_b !== 0 || acc_b !== 3 || busy_b !== 1'b0) begin errors++;
            $display("FAIL short_clean got underruns=%0d acc=%0d busy=%b want 0 3 0",
                     nunder_b, acc_b, busy_b); end
    endtask

    initial begin
        reset_a = 1'b1; data_valid_a = 1'b0; data_in_a = 8'h00;
        reset_b = 1'b1; data_valid_b = 1'b0; data_in_b = 8'h00;
        test_reset();
        test_frame();
        test_loopback();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_short_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
